// File: rtl/mem_pkg.sv
// Shared types and funct3 encodings for the M-stage data-memory bridge.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic f3_aligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return ~off[0];
            2'b10:   return (off == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (i_off)
            2'd0:    byte_v = i_word[7:0];
            2'd1:    byte_v = i_word[15:8];
            2'd2:    byte_v = i_word[23:16];
            default: byte_v = i_word[31:24];
        endcase
        half_v = i_off[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    o_data = {{16{half_v[15]}}, half_v};
            F3_BU:   o_data = {24'b0, byte_v};
            F3_HU:   o_data = {16'b0, half_v};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges M-stage loads/stores onto a req/ack data-memory bus, stalling the
// pipeline until the transfer completes, errors or times out.
module dmem_bridge
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err
);

    localparam int unsigned CLOG_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    dmem_state_t      state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       off_q, off_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        access, aligned, start;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ext_data;

    assign access  = i_re | i_we;
    assign aligned = f3_aligned(i_funct3, i_addr[1:0]);
    assign start   = access & aligned;

    // Stores drive only the addressed lanes; data is replicated so every lane carries it.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = i_wdata;
        if (i_we) begin
            case (i_funct3[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << i_addr[1:0];
                    lane_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    lane_be    = 4'b0011 << i_addr[1:0];
                    lane_wdata = {2{i_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (i_bus_ack || (cnt_q == TO_VAL)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack wins over timeout when both land in the same REQ cycle.
    always_comb begin
        addr_d  = addr_q;
        off_d   = off_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = {i_addr[31:2], 2'b00};
                    off_d   = i_addr[1:0];
                    we_d    = i_we;
                    f3_d    = i_funct3;
                    wdata_d = lane_wdata;
                    be_d    = lane_be;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (i_bus_ack) begin
                    rdata_d = i_bus_rdata;
                    err_d   = i_bus_err;
                end else if (cnt_q == TO_VAL) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    load_extender u_load_extender (
        .i_word   (rdata_q),
        .i_off    (off_q),
        .i_funct3 (f3_q),
        .o_data   (ext_data)
    );

    always_comb begin
        o_bus_req   = (state_q == REQ);
        o_bus_we    = we_q;
        o_bus_addr  = addr_q;
        o_bus_wdata = wdata_q;
        o_bus_be    = be_q;
        o_stall     = rst & (((state_q == IDLE) & start) | (state_q == REQ));
        o_misalign  = rst & (state_q == IDLE) & access & ~aligned;
        o_err       = (state_q == DONE) & err_q;
        o_rdata     = ((state_q == DONE) & ~we_q & ~err_q) ? ext_data : '0;
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed table, reset/timeout sequences
// and randomized accesses checked against a behavioural model.
module tb_dmem_bridge;

    localparam int unsigned TO = 4;

    logic        clk, rst;
    logic [31:0] i_addr, i_wdata;
    logic        i_we, i_re;
    logic [2:0]  i_funct3;
    logic [31:0] o_rdata;
    logic        o_stall, o_misalign, o_err;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_we        (i_we),
        .i_re        (i_re),
        .i_funct3    (i_funct3),
        .o_rdata     (o_rdata),
        .o_stall     (o_stall),
        .o_misalign  (o_misalign),
        .o_err       (o_err),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .o_bus_be    (o_bus_be),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
        .i_bus_err   (i_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int unsigned waits;
        logic [31:0] brd;
        logic        berr;
        logic        mis;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                input int unsigned waits, input logic [31:0] brd,
                                input logic berr, input logic mis,
                                input logic [31:0] baddr, input logic [3:0] be,
                                input logic [31:0] bwdata, input logic [31:0] rdata,
                                input logic err);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.waits = waits; v.brd = brd; v.berr = berr; v.mis = mis;
        v.exp_baddr = baddr; v.exp_be = be; v.exp_bwdata = bwdata;
        v.exp_rdata = rdata; v.exp_err = err;
        return v;
    endfunction

    // Behavioural model: lane arithmetic and extension derived from access rules.
    function automatic vec_t model(input logic we, input logic re, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] f3,
                                   input int unsigned waits, input logic [31:0] brd,
                                   input logic berr);
        vec_t v;
        int unsigned off;
        logic [31:0] shifted, b, h;
        off = int'(addr[1:0]);
        v = mk(we, re, addr, wdata, f3, waits, brd, berr, 1'b0, addr & 32'hFFFF_FFFC,
               4'hF, wdata, 32'h0, 1'b0);
        v.mis = ((f3 & 3'd3) == 3'd1 && (off % 2) != 0) || ((f3 & 3'd3) == 3'd2 && off != 0);
        if (we) begin
            if ((f3 & 3'd3) == 3'd0) begin
                v.exp_be = 4'(1 << off);
                v.exp_bwdata = (wdata & 32'hFF) * 32'h0101_0101;
            end else if ((f3 & 3'd3) == 3'd1) begin
                v.exp_be = 4'(3 << off);
                v.exp_bwdata = (wdata & 32'hFFFF) * 32'h0001_0001;
            end
        end
        v.exp_err = berr || (waits > TO);
        if (waits > TO) v.exp_err = 1'b1;
        if (!we && !v.exp_err) begin
            shifted = brd >> (8 * off);
            b = shifted & 32'hFF;
            h = shifted & 32'hFFFF;
            case (f3)
                3'd0:    v.exp_rdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                3'd1:    v.exp_rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                3'd4:    v.exp_rdata = b;
                3'd5:    v.exp_rdata = h;
                default: v.exp_rdata = brd;
            endcase
        end
        if (berr && waits <= TO) v.exp_err = 1'b1;
        else if (waits <= TO) v.exp_err = 1'b0;
        return v;
    endfunction

    task automatic idle_inputs();
        i_we = 1'b0; i_re = 1'b0; i_addr = '0; i_wdata = '0; i_funct3 = '0;
        i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
    endtask

    // Entered at posedge+1; returns at posedge+1 of the cycle after the access settles.
    task automatic run_vec(input vec_t v);
        int unsigned req_exp, stall_n;
        logic tmo;
        i_we = v.we; i_re = v.re; i_addr = v.addr; i_wdata = v.wdata; i_funct3 = v.f3;
        i_bus_ack = 1'b1; i_bus_err = 1'b1; i_bus_rdata = $urandom;
        #4;
        if (v.mis) begin
            chk("mis_pulse", 32'(o_misalign), 32'd1);
            chk("mis_stall", 32'(o_stall), 32'd0);
            chk("mis_req", 32'(o_bus_req), 32'd0);
            chk("mis_rdata", o_rdata, 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            #4;
            chk("mis_noreq", 32'(o_bus_req), 32'd0);
            chk("mis_nopulse", 32'(o_misalign), 32'd0);
            @(posedge clk); #1;
            return;
        end
        chk("idle_stall", 32'(o_stall), 32'd1);
        chk("idle_misalign", 32'(o_misalign), 32'd0);
        stall_n = o_stall ? 1 : 0;
        tmo = (v.waits > TO);
        req_exp = tmo ? TO + 1 : v.waits + 1;
        for (int unsigned k = 0; k < req_exp; k++) begin
            @(posedge clk); #1;
            i_bus_ack   = !tmo && (k == v.waits);
            i_bus_rdata = i_bus_ack ? v.brd : $urandom;
            i_bus_err   = i_bus_ack ? v.berr : 1'b0;
            #4;
            chk("req_high", 32'(o_bus_req), 32'd1);
            if (o_stall) stall_n++;
            chk("bus_addr", o_bus_addr, v.exp_baddr);
            chk("bus_be", 32'(o_bus_be), 32'(v.exp_be));
            chk("bus_we", 32'(o_bus_we), 32'(v.we));
            if (v.we) chk("bus_wdata", o_bus_wdata, v.exp_bwdata);
        end
        @(posedge clk); #1;
        i_bus_ack = 1'b0; i_bus_err = 1'b0;
        #4;
        chk("done_stall", 32'(o_stall), 32'd0);
        chk("done_req", 32'(o_bus_req), 32'd0);
        chk("done_rdata", o_rdata, v.exp_rdata);
        chk("done_err", 32'(o_err), 32'(v.exp_err));
        chk("stall_cycles", stall_n, req_exp + 1);
        @(posedge clk); #1;
        idle_inputs();
        #4;
        chk("after_err", 32'(o_err), 32'd0);
        chk("after_req", 32'(o_bus_req), 32'd0);
        chk("after_rdata", o_rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        vec_t rv;
        logic we, re;

        tbl[0]  = mk(1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        tbl[1]  = mk(0, 1, 32'h203, 32'h0, 3'b000, 0, 32'h80FF_1234, 0, 0, 32'h200, 4'b1111, 32'h0, 32'hFFFF_FF80, 0);
        tbl[2]  = mk(0, 1, 32'h203, 32'h0, 3'b100, 0, 32'h80FF_1234, 0, 0, 32'h200, 4'b1111, 32'h0, 32'h0000_0080, 0);
        tbl[3]  = mk(1, 0, 32'h302, 32'h0000_ABCD, 3'b001, 0, 32'h0, 0, 0, 32'h300, 4'b1100, 32'hABCD_ABCD, 32'h0, 0);
        tbl[4]  = mk(0, 1, 32'h101, 32'h0, 3'b010, 0, 32'h0, 0, 1, 32'h0, 4'b0, 32'h0, 32'h0, 0);
        tbl[5]  = mk(0, 1, 32'h180, 32'h0, 3'b010, 99, 32'h0, 0, 0, 32'h180, 4'b1111, 32'h0, 32'h0, 1);
        tbl[6]  = mk(0, 1, 32'h202, 32'h0, 3'b001, 2, 32'h80FF_1234, 0, 0, 32'h200, 4'b1111, 32'h0, 32'hFFFF_80FF, 0);
        tbl[7]  = mk(0, 1, 32'h202, 32'h0, 3'b101, 2, 32'h80FF_1234, 0, 0, 32'h200, 4'b1111, 32'h0, 32'h0000_80FF, 0);
        tbl[8]  = mk(0, 1, 32'h20C, 32'h0, 3'b010, 1, 32'h1234_5678, 0, 0, 32'h20C, 4'b1111, 32'h0, 32'h1234_5678, 0);
        tbl[9]  = mk(0, 1, 32'h010, 32'h0, 3'b010, 0, 32'hAAAA_AAAA, 1, 0, 32'h010, 4'b1111, 32'h0, 32'h0, 1);
        tbl[10] = mk(1, 0, 32'h101, 32'h0000_00A5, 3'b000, 0, 32'h0, 0, 0, 32'h100, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0);
        tbl[11] = mk(1, 0, 32'h301, 32'h0000_1111, 3'b001, 0, 32'h0, 0, 1, 32'h0, 4'b0, 32'h0, 32'h0, 0);
        tbl[12] = mk(0, 1, 32'h040, 32'h0, 3'b011, 0, 32'hCAFE_F00D, 0, 0, 32'h040, 4'b1111, 32'h0, 32'hCAFE_F00D, 0);
        tbl[13] = mk(0, 1, 32'h050, 32'h0, 3'b010, TO, 32'h0102_0304, 0, 0, 32'h050, 4'b1111, 32'h0, 32'h0102_0304, 0);

        idle_inputs();
        rst = 1'b0;
        i_re = 1'b1; i_funct3 = 3'b010; i_addr = 32'h100;
        #3;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_req", 32'(o_bus_req), 32'd0);
        chk("rst_misalign", 32'(o_misalign), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_be", 32'(o_bus_be), 32'd0);
        chk("rst_addr", o_bus_addr, 32'd0);
        idle_inputs();
        #9 rst = 1'b1;
        @(posedge clk); #1;

        for (int unsigned i = 0; i < 14; i++) run_vec(tbl[i]);

        // Reset during the second REQ cycle of a load that would wait 3 cycles.
        i_re = 1'b1; i_funct3 = 3'b010; i_addr = 32'h400;
        #4;
        chk("rr_idle_stall", 32'(o_stall), 32'd1);
        @(posedge clk); #5;
        chk("rr_req1", 32'(o_bus_req), 32'd1);
        @(posedge clk); #2;
        chk("rr_req2", 32'(o_bus_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("rr_req_drop", 32'(o_bus_req), 32'd0);
        chk("rr_stall_drop", 32'(o_stall), 32'd0);
        chk("rr_err", 32'(o_err), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        #2 rst = 1'b1;
        #2;
        chk("rr_post_req", 32'(o_bus_req), 32'd0);
        chk("rr_post_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        run_vec(mk(0, 1, 32'h404, 32'h0, 3'b010, 0, 32'h5566_7788, 0, 0, 32'h404, 4'b1111, 32'h0, 32'h5566_7788, 0));

        for (int unsigned i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            rv = model(we, re, $urandom, $urandom, 3'($urandom_range(0, 7)),
                       $urandom_range(0, TO + 1), $urandom, ($urandom_range(0, 7) == 0));
            run_vec(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
